// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic multiplier read-out path.
`timescale 1ns/1ps
package systolic_pkg;

   // Accumulator result width, common to mac_unit acc_out and the drain.
   localparam int ACC_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      STREAM,
      DONE
   } drain_state_t;

endpackage

// File: rtl/drain_row_buffer.sv
// One row of accumulator results, loaded in parallel and read back by column.
`timescale 1ns/1ps
module drain_row_buffer
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = ACC_DATA_W,
   parameter int IDX_W  = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [N*DATA_W-1:0] row_data,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic [DATA_W-1:0]   rd_val
);

   logic [DATA_W-1:0] mem [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < N; i++) mem[i] <= row_data[i*DATA_W +: DATA_W];
      end
   end

   assign rd_val = mem[rd_idx];

endmodule

// File: rtl/systolic_result_drain.sv
// Drains the N x N accumulator grid row by row and streams it out
// element by element with row/column tags.
`timescale 1ns/1ps
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = ACC_DATA_W,
   parameter int IDX_W  = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                rd_en,
   output logic [IDX_W-1:0]    rd_row,
   input  logic [N*DATA_W-1:0] rd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [IDX_W-1:0]    out_row,
   output logic [IDX_W-1:0]    out_col,
   output logic                out_last
);

   // Stream handshake: an element transfers on the rising edge where
   // out_valid && out_ready. Once raised, out_valid and the element fields
   // stay stable until that edge; out_valid never depends on out_ready.

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   drain_state_t      state;
   logic [IDX_W-1:0]  row;
   logic [IDX_W-1:0]  col;
   logic [IDX_W-1:0]  next_col;
   logic [DATA_W-1:0] next_val;

   assign next_col = col + IDX_W'(1);

   // Output data is registered, so the buffer is read one column ahead.
   drain_row_buffer #(
      .N      (N),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_row_buffer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == WAIT),
      .row_data (rd_data),
      .rd_idx   (next_col),
      .rd_val   (next_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         col       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_row    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= REQ;
                  row    <= '0;
                  busy   <= 1'b1;
                  rd_en  <= 1'b1;
                  rd_row <= '0;
               end
            end
            REQ: begin
               state <= WAIT;
               rd_en <= 1'b0;
            end
            WAIT: begin
               // Column 0 comes straight from the bus; the buffer is loading now.
               state     <= STREAM;
               col       <= '0;
               out_valid <= 1'b1;
               out_data  <= rd_data[0 +: DATA_W];
               out_row   <= row;
               out_col   <= '0;
               out_last  <= 1'b0;
            end
            STREAM: begin
               if (out_ready) begin
                  if (col != LAST_IDX) begin
                     col      <= next_col;
                     out_data <= next_val;
                     out_col  <= next_col;
                     out_last <= (row == LAST_IDX) && (next_col == LAST_IDX);
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (row != LAST_IDX) begin
                        state  <= REQ;
                        row    <= row + IDX_W'(1);
                        rd_en  <= 1'b1;
                        rd_row <= row + IDX_W'(1);
                     end else begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               row   <= '0;
               col   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized bench for systolic_result_drain: a PE-array read model feeds
// rows, and a row-major scoreboard checks the tagged output stream.
`timescale 1ns/1ps
module tb_systolic_result_drain;

   localparam int N      = 4;
   localparam int DATA_W = 16;
   localparam int IDX_W  = $clog2(N);

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic                busy;
   logic                done;
   logic                rd_en;
   logic [IDX_W-1:0]    rd_row;
   logic [N*DATA_W-1:0] rd_data;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_data;
   logic [IDX_W-1:0]    out_row;
   logic [IDX_W-1:0]    out_col;
   logic                out_last;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] mat [N][N];
   logic [31:0]       exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   systolic_result_drain #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_row    (rd_row),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   // PE array read port: row appears the cycle after rd_en, garbage otherwise.
   logic             pe_en;
   logic [IDX_W-1:0] pe_row;
   always begin
      @(negedge clk);
      pe_en  = rd_en;
      pe_row = rd_row;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++)
         rd_data[c*DATA_W +: DATA_W] = pe_en ? mat[pe_row][c] : DATA_W'($urandom);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c,
                                        input logic l, input logic [DATA_W-1:0] d);
      return 32'({r, c, l, d});
   endfunction

   function automatic logic [63:0] all_outputs();
      return 64'({busy, done, rd_en, rd_row, out_valid, out_data, out_row, out_col, out_last});
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic fill_matrix(input int kind);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            mat[r][c] = (kind == 0) ? DATA_W'(16 * r + c) : DATA_W'($urandom);
      if (kind == 1) begin
         mat[0][0] = -16'sd32129;
         mat[0][1] = 16'sd32129;
         mat[0][2] = -16'sd128;
         mat[0][3] = 16'sd16384;
      end
   endtask

   // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
   task automatic run_drain(input int mode, input bit poke, input bit tail);
      int          cyc, strobes, dones, lat;
      bit          stalled, poked;
      logic [31:0] prev, obs;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_q.push_back(pack(IDX_W'(r), IDX_W'(c), (r == N-1) && (c == N-1), mat[r][c]));
      cyc = 0; strobes = 0; dones = 0; lat = 0; stalled = 0; poked = 0; prev = '0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (dones == 0 && cyc < 400) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         start = 1'b0;
         if (poke && !poked && out_valid && out_row == 1 && out_col == 2) begin
            start = 1'b1;
            poked = 1;
         end
         @(negedge clk);
         cyc++;
         obs = pack(out_row, out_col, out_last, out_data);
         if (rd_en) begin
            check("rd_row", 64'(rd_row), 64'(strobes));
            strobes++;
         end
         if (stalled) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_elem", 64'(obs), 64'(prev));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_elem", 64'd1, 64'd0);
            else check("elem", 64'(obs), 64'(exp_q.pop_front()));
         end
         stalled = out_valid && !out_ready;
         prev    = obs;
         if (done) begin
            dones++;
            lat = cyc;
         end
         if (dones == 0) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      if (dones == 0) check("done_timeout", 64'd0, 64'd1);
      if (mode == 0) check("latency", 64'(lat), 64'(N * (N + 2) + 1));
      if (poke) check("poke_seen", 64'(poked), 64'd1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      if (tail) begin
         repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) dones++;
            if (rd_en) strobes++;
         end
         check("done_count", 64'(dones), 64'd1);
         check("busy_after", 64'(busy), 64'd0);
      end
      check("rd_strobes", 64'(strobes), 64'(N));
      exp_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; rd_data = '0;
      fill_matrix(0);
      repeat (3) @(posedge clk);
      #1 check("reset_outputs", all_outputs(), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", 64'({busy, rd_en, out_valid}), 64'd0);
      end

      fill_matrix(0); run_drain(0, 0, 1);
      fill_matrix(1); run_drain(1, 0, 1);
      fill_matrix(2); run_drain(2, 1, 1);
      fill_matrix(2); run_drain(0, 0, 0); run_drain(0, 0, 1);

      // Reset while streaming.
      fill_matrix(2);
      @(posedge clk); #1 start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("reach_stream", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1 check("midreset_outputs", all_outputs(), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("post_reset_idle", 64'({busy, rd_en, out_valid, done}), 64'd0);
      end

      fill_matrix(0); run_drain(2, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
